// File: rtl/player_compositor_if.sv
// Pixel-rate signal bundle between the playfield/CPU side and the player compositor.
// All CPU-side values arrive already synchronised to the pixel clock.
interface player_compositor_if;
  logic       in_image;
  logic [9:0] pos_x;
  logic       line_start;
  logic       pf_fg;
  logic [6:0] color_fg, color_bg, color_p0, color_p1;
  logic       pf_priority;
  logic [7:0] grp0_data, grp1_data;
  logic       grp0_load, grp1_load;
  logic [9:0] posp0_data, posp1_data;
  logic       posp0_load, posp1_load;
  logic       refp0, refp1;
  logic       collision_clear;
  logic [6:0] color;
  logic [2:0] collisions;

  modport master (
    output in_image, pos_x, line_start, pf_fg,
           color_fg, color_bg, color_p0, color_p1, pf_priority,
           grp0_data, grp1_data, grp0_load, grp1_load,
           posp0_data, posp1_data, posp0_load, posp1_load,
           refp0, refp1, collision_clear,
    input  color, collisions
  );

  modport slave (
    input  in_image, pos_x, line_start, pf_fg,
           color_fg, color_bg, color_p0, color_p1, pf_priority,
           grp0_data, grp1_data, grp0_load, grp1_load,
           posp0_data, posp1_data, posp0_load, posp1_load,
           refp0, refp1, collision_clear,
    output color, collisions
  );
endinterface

// File: rtl/player_compositor.sv
// Adds two 8-bit player sprites to the playfield pixel stream, resolves priority
// and latches sticky collision flags. Sprite registers are double-buffered per line.

module player_sprite #(
  parameter int PIXEL_SCALE = 4,
  parameter int IMAGE_WIDTH = 720
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start_i,
  input  logic [7:0] grp_data_i,
  input  logic       grp_load_i,
  input  logic [9:0] pos_data_i,
  input  logic       pos_load_i,
  input  logic       refp_i,
  input  logic [9:0] pos_x_i,
  output logic       hit_o
);
  localparam int          SHIFT = $clog2(PIXEL_SCALE);
  localparam logic [10:0] SPAN  = 11'(8 * PIXEL_SCALE);
  localparam logic [10:0] IW    = 11'(IMAGE_WIDTH);

  logic [7:0]  grp_sh_q, grp_sh_d, grp_act_q, grp_act_d;
  logic [9:0]  pos_sh_q, pos_sh_d, pos_act_q, pos_act_d;
  logic [10:0] d;
  logic [2:0]  idx;
  logic        in_span;

  // The shadow next-state feeds the commit so a load on line_start lands this line.
  always_comb begin
    grp_sh_d  = grp_load_i   ? grp_data_i : grp_sh_q;
    pos_sh_d  = pos_load_i   ? pos_data_i : pos_sh_q;
    grp_act_d = line_start_i ? grp_sh_d   : grp_act_q;
    pos_act_d = line_start_i ? pos_sh_d   : pos_act_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_sh_q  <= '0;
      pos_sh_q  <= '0;
      grp_act_q <= '0;
      pos_act_q <= '0;
    end else begin
      grp_sh_q  <= grp_sh_d;
      pos_sh_q  <= pos_sh_d;
      grp_act_q <= grp_act_d;
      pos_act_q <= pos_act_d;
    end
  end

  always_comb begin
    d       = {1'b0, pos_x_i} - {1'b0, pos_act_q};
    in_span = (pos_x_i >= pos_act_q) && (d < SPAN) && ({1'b0, pos_act_q} < IW);
    idx     = 3'(d >> SHIFT);
    hit_o   = in_span && (refp_i ? grp_act_q[idx] : grp_act_q[3'd7 - idx]);
  end
endmodule

module player_compositor #(
  parameter int PIXEL_SCALE = 4,
  parameter int IMAGE_WIDTH = 720
) (
  input logic              clk,
  input logic              reset,
  player_compositor_if.slave bus
);
  localparam int NUM_P = 2;

  if (!(PIXEL_SCALE == 1 || PIXEL_SCALE == 2 || PIXEL_SCALE == 4 || PIXEL_SCALE == 8))
  begin : g_bad_scale
    $error("player_compositor: PIXEL_SCALE must be 1, 2, 4 or 8");
  end

  logic [NUM_P-1:0][7:0] grp_data;
  logic [NUM_P-1:0][9:0] pos_data;
  logic [NUM_P-1:0]      grp_load, pos_load, refp, p_hit;

  assign grp_data = {bus.grp1_data, bus.grp0_data};
  assign pos_data = {bus.posp1_data, bus.posp0_data};
  assign grp_load = {bus.grp1_load, bus.grp0_load};
  assign pos_load = {bus.posp1_load, bus.posp0_load};
  assign refp     = {bus.refp1, bus.refp0};

  for (genvar n = 0; n < NUM_P; n++) begin : g_p
    player_sprite #(.PIXEL_SCALE(PIXEL_SCALE), .IMAGE_WIDTH(IMAGE_WIDTH)) u_sprite (
      .clk         (clk),
      .reset       (reset),
      .line_start_i(bus.line_start),
      .grp_data_i  (grp_data[n]),
      .grp_load_i  (grp_load[n]),
      .pos_data_i  (pos_data[n]),
      .pos_load_i  (pos_load[n]),
      .refp_i      (refp[n]),
      .pos_x_i     (bus.pos_x),
      .hit_o       (p_hit[n])
    );
  end

  logic [6:0] color_q, color_d;
  logic [2:0] coll_q, coll_d, coll_set;

  always_comb begin
    color_d  = '0;
    coll_set = '0;
    if (bus.in_image) begin
      coll_set = {p_hit[0] & p_hit[1], p_hit[1] & bus.pf_fg, p_hit[0] & bus.pf_fg};
      if (bus.pf_priority && bus.pf_fg) color_d = bus.color_fg;
      else if (p_hit[0])                color_d = bus.color_p0;
      else if (p_hit[1])                color_d = bus.color_p1;
      else if (bus.pf_fg)               color_d = bus.color_fg;
      else                              color_d = bus.color_bg;
    end
    // A new hit outranks a simultaneous clear.
    coll_d = (coll_q & ~{3{bus.collision_clear}}) | coll_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= '0;
      coll_q  <= '0;
    end else begin
      color_q <= color_d;
      coll_q  <= coll_d;
    end
  end

  assign bus.color      = color_q;
  assign bus.collisions = coll_q;
endmodule

// File: doc/player_compositor.md
Name: player_compositor

Overview:
- Pixel-domain stage fed by the playfield generator's per-pixel output.
- Adds two Atari-style 8-bit player sprites (P0, P1) and resolves priority among players, playfield and background. Its 7-bit color output drives the HDMI encoder's color input.
- Latches sticky collision flags that the CPU reads through the peripheral register block.
- All CPU-written values arrive already synchronised to the pixel clock as data+load strobes.

Parameters:
- PIXEL_SCALE, 4: output pixels per sprite pixel. Allowed values are 1, 2, 4 or 8; any other value is illegal.
- IMAGE_WIDTH, 720: visible columns per line.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- in_image  in  1  current pixel is inside the visible image
- pos_x  in  10  column within image, 0..IMAGE_WIDTH-1, valid when in_image
- line_start  in  1  one-cycle pulse before the first visible pixel of each line
- pf_fg  in  1  playfield bit set at this pixel
- color_fg, color_bg, color_p0, color_p1  in  7 each  palette indices
- pf_priority  in  1  1 = playfield drawn over players
- grp0_data, grp1_data  in  8 each  sprite graphics bytes
- grp0_load, grp1_load  in  1 each  write strobes for graphics
- posp0_data, posp1_data  in  10 each  sprite left column
- posp0_load, posp1_load  in  1 each  write strobes for position
- refp0, refp1  in  1 each  horizontal reflect, used combinationally
- collision_clear  in  1  clears all collision flags
- color  out  7  composited pixel color, registered
- collisions  out  3  {p0_p1, p1_pf, p0_pf}, sticky

Behaviour:
- Reset: all shadow registers, active registers, color and collisions go to 0 immediately.
- Shadow registers: each load strobe writes the corresponding shadow register (graphics or position) in that cycle.
- Commit: on line_start, all four shadow values copy to the active registers.
  - If a load and line_start occur in the same cycle, the new value reaches both shadow and active.
  - Mid-line loads never change the current line.
- Sprite hit for player n, combinational from active registers:
  - Compute d = pos_x - posp_n using 11-bit unsigned arithmetic.
  - The sprite is in span when pos_x >= posp_n and d < 8*PIXEL_SCALE.
  - idx = d >> log2(PIXEL_SCALE).
  - Hit bit = refp_n ? grp_n[idx] : grp_n[7-idx].
  - Spans do not wrap. A sprite with posp_n >= IMAGE_WIDTH is invisible; a sprite near the right edge is clipped.
- Priority:
  - pf_priority=0: P0 > P1 > playfield(color_fg) > color_bg.
  - pf_priority=1: playfield > P0 > P1 > color_bg.
- Output latency:
  - color is registered, exactly 1 clk after the pos_x/pf_fg/in_image sample.
  - When in_image=0, color is driven to 0 on the next edge.
- Collisions:
  - A flag sets on any in_image pixel where both sources hit.
  - Flags stay set until collision_clear.
  - If collision_clear and a new hit occur in the same cycle, the set wins.
  - Flags are updated on the same edge as color.
- No handshake back-pressure; the block processes one pixel per clk continuously.

Test Plan:
- Reset mid-line with grp0=0xFF → color=0 and collisions=0 at once; after release with no loads, every image pixel = color_bg.
- grp0=0x80, posp0=100, SCALE=4, refp0=0, committed by line_start → pos_x 100..103 give color_p0 one clk later; pos_x 104 gives bg.
- Same setup with refp0=1 → P0 pixels at pos_x 128..131 only.
- grp0=grp1=0xFF, posp0=200, posp1=210, pf_fg=1 throughout:
  - pf_priority=0 → P0 shows on 200..231, P1 on 232..241.
  - collisions = 3'b111 after the line.
  - Pulse collision_clear on a hit cycle → flags stay set; pulse on a non-hit cycle → 3'b000.
- Write grp1=0x0F mid-line (old value 0xF0) → the current line still shows 0xF0 pattern; next line after line_start shows 0x0F. Load coinciding with line_start → new pattern appears on that same line.
- posp0=716 with grp0=0xFF → P0 visible at 716..719 only, nothing at column 0. posp0=800 → no P0 pixels and no P0 collisions.
